// File: rtl/cla_stream_accumulator.sv
// Stream accumulator built around a 32-bit carry-look-ahead adder.
// Frame words are summed into a low word; the adder carry-out bumps an
// extension counter, and the frame total is held on a valid/ready port.

// 4-bit look-ahead slice: local sum plus group propagate/generate.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       gp,
  output logic       gg
);
  logic [3:0] g, p;
  logic [3:1] c;
  // carries inside the slice resolved in parallel from g/p/cin
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    s    = p ^ {c[3], c[2], c[1], cin};
    gp   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end
endmodule

// W-bit adder: array of 4-bit slices chained through group g/p.
module cla_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  localparam int NG = W / 4;
  logic [NG:0]   c;
  logic [NG-1:0] gp, gg;

  assign c[0] = cin;
  assign cout = c[NG];

  genvar i;
  generate
    for (i = 0; i < NG; i++) begin : g_grp
      cla4 u_cla4 (
        .a  (a[4*i +: 4]),
        .b  (b[4*i +: 4]),
        .cin(c[i]),
        .s  (s[4*i +: 4]),
        .gp (gp[i]),
        .gg (gg[i])
      );
      assign c[i+1] = gg[i] | (gp[i] & c[i]);
    end
  endgenerate
endmodule

module cla_stream_accumulator #(
  parameter int DATA_W = 32,
  parameter int EXT_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W+EXT_W-1:0] out_sum,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_overflow
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
  logic [EXT_W-1:0]  ext_q, ext_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] sum;
  logic              cout;
  logic              accept;

  cla_adder #(.W(DATA_W)) u_add (
    .a   (acc_lo_q),
    .b   (in_data),
    .cin (1'b0),
    .s   (sum),
    .cout(cout)
  );

  assign in_ready     = (state_q != HOLD);
  assign out_valid    = (state_q == HOLD);
  assign accept       = in_valid & in_ready;
  assign out_sum      = {ext_q, acc_lo_q};
  assign out_count    = count_q;
  assign out_overflow = ovf_q;

  // next-state: accumulate on accept, clear after the result handshake
  always_comb begin
    state_d  = state_q;
    acc_lo_d = acc_lo_q;
    ext_d    = ext_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (accept) begin
      acc_lo_d = sum;
      ext_d    = ext_q + EXT_W'(cout);
      ovf_d    = ovf_q | (cout & (&ext_q));
      count_d  = (&count_q) ? count_q : count_q + CNT_W'(1);
      state_d  = in_last ? HOLD : ACC;
    end else if (state_q == HOLD && out_ready) begin
      state_d  = IDLE;
      acc_lo_d = '0;
      ext_d    = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_lo_q <= '0;
      ext_q    <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_lo_q <= acc_lo_d;
      ext_q    <= ext_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_cla_stream_accumulator.sv
// Directed bench: default instance (EXT_W=8) plus a narrow-extension
// instance (EXT_W=2) for the wrap/overflow case.
module tb_cla_stream_accumulator;
  logic        clk = 0;
  logic        rst;
  // default instance
  logic        in_valid, in_last, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, out_overflow;
  logic [39:0] out_sum;
  logic [15:0] out_count;
  // EXT_W=2 instance
  logic        v2, l2, r2;
  logic [31:0] d2;
  logic        rdy2, ov2, ovf2;
  logic [33:0] sum2;
  logic [15:0] cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cla_stream_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .out_overflow(out_overflow)
  );

  cla_stream_accumulator #(.EXT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2),
    .in_data(d2), .in_last(l2), .out_valid(ov2),
    .out_ready(r2), .out_sum(sum2), .out_count(cnt2),
    .out_overflow(ovf2)
  );

  // one beat on the selected instance; returns #1 after the edge
  task automatic beat(input bit sel, input logic [31:0] d, input logic l);
    if (!sel) begin in_valid = 1; in_data = d; in_last = l; end
    else      begin v2 = 1; d2 = d; l2 = l; end
    @(posedge clk); #1;
    in_valid = 0; in_last = 0; v2 = 0; l2 = 0;
  endtask

  task automatic handshake();
    out_ready = 1; r2 = 1;
    @(posedge clk); #1;
    out_ready = 0; r2 = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 40'd0 ||
        out_count !== 16'd0 || out_overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset: rdy=%b vld=%b sum=%h cnt=%0d ovf=%b, want 1 0 0 0 0",
               in_ready, out_valid, out_sum, out_count, out_overflow);
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    beat(0, 32'd1, 0);
    beat(0, 32'd2, 0);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL basic_early_valid: got %b want 0", out_valid);
    end
    beat(0, 32'd3, 1);
    tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL basic_latency: vld=%b rdy=%b want 1 0", out_valid, in_ready);
    end
    tests++;
    if (out_sum !== 40'd6 || out_count !== 16'd3 || out_overflow !== 1'b0) begin
      fails++;
      $display("FAIL basic_result: sum=%h cnt=%0d ovf=%b want 6 3 0", out_sum, out_count, out_overflow);
    end
    handshake();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 40'd0 || out_count !== 16'd0) begin
      fails++;
      $display("FAIL basic_clear: vld=%b rdy=%b sum=%h cnt=%0d want 0 1 0 0",
               out_valid, in_ready, out_sum, out_count);
    end
  endtask

  task automatic test_carry();
    beat(0, 32'hFFFF_FFFF, 0);
    beat(0, 32'hFFFF_FFFF, 0);
    beat(0, 32'hFFFF_FFFF, 1);
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 40'h02_FFFF_FFFD || out_count !== 16'd3 ||
        out_overflow !== 1'b0) begin
      fails++;
      $display("FAIL carry: vld=%b sum=%h cnt=%0d ovf=%b want 1 02fffffffd 3 0",
               out_valid, out_sum, out_count, out_overflow);
    end
    handshake();
  endtask

  task automatic test_ext_overflow();
    for (int i = 0; i < 4; i++) beat(1, 32'hFFFF_FFFF, 0);
    tests++;
    if (sum2 !== 34'h3_FFFF_FFFC || ovf2 !== 1'b0) begin
      fails++; $display("FAIL ovf_before_wrap: sum=%h ovf=%b want 3fffffffc 0", sum2, ovf2);
    end
    beat(1, 32'hFFFF_FFFF, 1);
    tests++;
    if (ov2 !== 1'b1 || sum2 !== 34'h0_FFFF_FFFB || ovf2 !== 1'b1 || cnt2 !== 16'd5) begin
      fails++;
      $display("FAIL ovf_wrap: vld=%b sum=%h ovf=%b cnt=%0d want 1 0fffffffb 1 5",
               ov2, sum2, ovf2, cnt2);
    end
    handshake();
    tests++;
    if (ovf2 !== 1'b0 || sum2 !== 34'd0) begin
      fails++; $display("FAIL ovf_clear: sum=%h ovf=%b want 0 0", sum2, ovf2);
    end
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    beat(0, 32'hA5, 1);
    // offer a beat while holding; it must not be taken
    in_valid = 1; in_data = 32'h1234; in_last = 1;
    for (int i = 0; i < 5; i++) begin
      if (out_sum !== 40'hA5 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_count !== 16'd1)
        bad++;
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL hold_stable: %0d bad cycles, want 0 (sum=%h)", bad, out_sum);
    end
    handshake();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 40'd0) begin
      fails++; $display("FAIL hold_release: vld=%b rdy=%b sum=%h want 0 1 0", out_valid, in_ready, out_sum);
    end
    beat(0, 32'd1, 1);
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 40'd1 || out_count !== 16'd1) begin
      fails++; $display("FAIL hold_next_frame: vld=%b sum=%h cnt=%0d want 1 1 1", out_valid, out_sum, out_count);
    end
    handshake();
  endtask

  task automatic test_bubbles();
    beat(0, 32'd10, 0);
    repeat (3) begin @(posedge clk); #1; end
    tests++;
    if (out_sum !== 40'd10 || out_count !== 16'd1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL bubble_hold: sum=%h cnt=%0d vld=%b want a 1 0", out_sum, out_count, out_valid);
    end
    beat(0, 32'd20, 0);
    repeat (3) begin @(posedge clk); #1; end
    beat(0, 32'd30, 1);
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 40'd60 || out_count !== 16'd3) begin
      fails++; $display("FAIL bubbles: vld=%b sum=%h cnt=%0d want 1 3c 3", out_valid, out_sum, out_count);
    end
    handshake();
  endtask

  task automatic test_mid_reset();
    beat(0, 32'd7, 0);
    beat(0, 32'd7, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 40'd0 || out_count !== 16'd0) begin
      fails++;
      $display("FAIL midreset: rdy=%b vld=%b sum=%h cnt=%0d want 1 0 0 0",
               in_ready, out_valid, out_sum, out_count);
    end
    beat(0, 32'd5, 1);
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 40'd5 || out_count !== 16'd1) begin
      fails++; $display("FAIL midreset_frame: vld=%b sum=%h cnt=%0d want 1 5 1", out_valid, out_sum, out_count);
    end
    handshake();
  endtask

  initial begin
    in_valid = 0; in_last = 0; in_data = 0; out_ready = 0;
    v2 = 0; l2 = 0; d2 = 0; r2 = 0;
    test_reset();
    test_basic();
    test_carry();
    test_ext_overflow();
    test_hold();
    test_bubbles();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
